// File: rtl/text_cmd_engine.sv
// Text-mode command engine: takes opcode/param word pairs, keeps the cursor and
// drives the character RAM write port, including fill and hardware scroll-up.
module text_cmd_engine #(
  parameter int COLS   = 40,
  parameter int ROWS   = 25,
  parameter int CHAR_W = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [15:0]       cmd_data,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [CHAR_W-1:0] ram_wdata,
  input  logic [CHAR_W-1:0] ram_rdata,
  output logic [7:0]        cursor_x,
  output logic [7:0]        cursor_y,
  output logic              busy
);
  typedef enum logic [2:0] {
    S_OP, S_PARAM, S_EXEC, S_FILL, S_SCROLL_RD, S_SCROLL_WR, S_BLANK
  } state_t;

  localparam logic [15:0] OP_CLEAR  = 16'h00C0;
  localparam logic [15:0] OP_PUTC   = 16'h00C1;
  localparam logic [15:0] OP_BS     = 16'h00C2;
  localparam logic [15:0] OP_SETY   = 16'h00C3;
  localparam logic [15:0] OP_SETX   = 16'h00C4;
  localparam logic [15:0] OP_CLEAR2 = 16'h00C5;
  localparam logic [15:0] OP_NL     = 16'h00C6;
  localparam logic [15:0] OP_SCROLL = 16'h00C7;
  localparam logic [15:0] OP_FILL   = 16'h00C8;

  localparam logic [ADDR_W-1:0] COLS_A      = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_CELL   = ADDR_W'(COLS*ROWS-1);
  localparam logic [ADDR_W-1:0] SCROLL_LAST = ADDR_W'((ROWS-1)*COLS-1);
  localparam logic [7:0]        X_MAX       = 8'(COLS-1);
  localparam logic [7:0]        Y_MAX       = 8'(ROWS-1);

  state_t            state;
  logic [15:0]       op_reg, param_reg;
  logic              we_reg, re_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [CHAR_W-1:0] wdata_reg;
  logic [7:0]        cx, cy, pend_x, pend_y;
  logic [ADDR_W-1:0] cursor_lin;

  assign cursor_lin = ADDR_W'(cy) * COLS_A + ADDR_W'(cx);
  assign cmd_ready  = (state == S_OP) || (state == S_PARAM);
  assign busy       = (state == S_FILL) || (state == S_SCROLL_RD) ||
                      (state == S_SCROLL_WR) || (state == S_BLANK);
  assign ram_we     = we_reg;
  assign ram_re     = re_reg;
  assign ram_addr   = addr_reg;
  // Read data arrives during the write cycle, so it is forwarded straight through.
  assign ram_wdata  = (state == S_SCROLL_WR) ? ram_rdata : wdata_reg;
  assign cursor_x   = cx;
  assign cursor_y   = cy;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= S_OP;
      op_reg    <= '0;
      param_reg <= '0;
      we_reg    <= 1'b0;
      re_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      cx        <= '0;
      cy        <= '0;
      pend_x    <= '0;
      pend_y    <= '0;
    end else begin
      case (state)
        S_OP: if (cmd_valid) begin
          op_reg <= cmd_data;
          state  <= S_PARAM;
        end
        S_PARAM: if (cmd_valid) begin
          param_reg <= cmd_data;
          state     <= S_EXEC;
          // Single-cell writes are set up here so they appear during EXEC.
          if (op_reg == OP_PUTC) begin
            we_reg    <= 1'b1;
            addr_reg  <= cursor_lin;
            wdata_reg <= cmd_data[CHAR_W-1:0];
          end else if (op_reg == OP_BS && (cx != 8'd0 || cy != 8'd0)) begin
            we_reg    <= 1'b1;
            addr_reg  <= cursor_lin - ADDR_W'(1);
            wdata_reg <= '0;
          end
        end
        S_EXEC: begin
          we_reg <= 1'b0;
          state  <= S_OP;
          if ((op_reg == OP_CLEAR && param_reg == 16'd0) || op_reg == OP_CLEAR2 ||
              op_reg == OP_FILL) begin
            state     <= S_FILL;
            we_reg    <= 1'b1;
            addr_reg  <= '0;
            wdata_reg <= (op_reg == OP_FILL) ? param_reg[CHAR_W-1:0] : '0;
            pend_x    <= '0;
            pend_y    <= '0;
          end else if (op_reg == OP_PUTC) begin
            if (cx != X_MAX) begin
              cx <= cx + 8'd1;
            end else if (cy != Y_MAX) begin
              cx <= '0;
              cy <= cy + 8'd1;
            end else begin
              state    <= S_SCROLL_RD;
              re_reg   <= 1'b1;
              addr_reg <= COLS_A;
              pend_x   <= '0;
              pend_y   <= Y_MAX;
            end
          end else if (op_reg == OP_BS) begin
            if (cx != 8'd0) begin
              cx <= cx - 8'd1;
            end else if (cy != 8'd0) begin
              cx <= X_MAX;
              cy <= cy - 8'd1;
            end
          end else if (op_reg == OP_SETY) begin
            cy <= (param_reg > 16'(ROWS-1)) ? Y_MAX : param_reg[7:0];
          end else if (op_reg == OP_SETX) begin
            cx <= (param_reg > 16'(COLS-1)) ? X_MAX : param_reg[7:0];
          end else if (op_reg == OP_NL) begin
            if (cy != Y_MAX) begin
              cx <= '0;
              cy <= cy + 8'd1;
            end else begin
              state    <= S_SCROLL_RD;
              re_reg   <= 1'b1;
              addr_reg <= COLS_A;
              pend_x   <= '0;
              pend_y   <= Y_MAX;
            end
          end else if (op_reg == OP_SCROLL) begin
            state    <= S_SCROLL_RD;
            re_reg   <= 1'b1;
            addr_reg <= COLS_A;
            pend_x   <= cx;
            pend_y   <= cy;
          end
        end
        S_FILL, S_BLANK: begin
          if (addr_reg == LAST_CELL) begin
            we_reg <= 1'b0;
            state  <= S_OP;
            cx     <= pend_x;
            cy     <= pend_y;
          end else begin
            addr_reg <= addr_reg + ADDR_W'(1);
          end
        end
        S_SCROLL_RD: begin
          // ram_addr doubles as the scroll counter: source = dest + COLS.
          re_reg   <= 1'b0;
          we_reg   <= 1'b1;
          addr_reg <= addr_reg - COLS_A;
          state    <= S_SCROLL_WR;
        end
        S_SCROLL_WR: begin
          if (addr_reg == SCROLL_LAST) begin
            state     <= S_BLANK;
            wdata_reg <= '0;
            addr_reg  <= addr_reg + ADDR_W'(1);
          end else begin
            we_reg   <= 1'b0;
            re_reg   <= 1'b1;
            addr_reg <= addr_reg + ADDR_W'(1) + COLS_A;
            state    <= S_SCROLL_RD;
          end
        end
        default: state <= S_OP;
      endcase
    end
  end
endmodule
